// File: rtl/ddr3_rw_checker.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rw_checker
// Purpose  : Self-checking DDR3 traffic engine. Once the controller reports
//            init complete, it writes an address-derived pattern over
//            TEST_BURSTS bursts, reads them back, compares every beat and
//            reports status on two LEDs and two counters.
// Ports    : sys_clk/sys_rst         - clock, synchronous active-high reset
//            init_done               - controller initialisation complete
//            aw*/w*                  - write address/data channel (master)
//            ar*/r*                  - read address/data channel (master)
//            led[0]                  - heartbeat while running
//            led[1]                  - sticky error flag
//            err_cnt                 - saturating mismatching-beat count
//            pass_cnt                - error-free completed passes (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_rw_checker #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_LEN   = 16,
  parameter int TEST_BURSTS = 64,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      init_done,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  output logic                      wlast,
  input  logic                      wready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic                      rvalid,
  input  logic                      rlast,
  output logic [1:0]                led,
  output logic [15:0]               err_cnt,
  output logic [15:0]               pass_cnt
);

  localparam int LANES       = DATA_WIDTH / 32;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W     = (TEST_BURSTS > 1) ? $clog2(TEST_BURSTS) : 1;
  localparam int BLINK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);
  localparam logic [7:0] LEN_FIELD = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    WR_ADDR   = 3'd1,
    WR_DATA   = 3'd2,
    RD_ADDR   = 3'd3,
    RD_DATA   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t               state, state_next;
  logic [BEAT_W-1:0]    beat;
  logic [BURST_W-1:0]   burst;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink;
  logic                 err_flag;
  logic                 pass_err;   // a mismatch was seen during this pass
  logic                 last_beat;
  logic                 last_burst;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 rd_mismatch;
  logic [23:0]          word_idx;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ADDR_WIDTH-1:0] burst_addr;

  assign last_beat  = (beat == BEAT_W'(BURST_LEN - 1));
  assign last_burst = (burst == BURST_W'(TEST_BURSTS - 1));
  assign wr_fire    = wvalid & wready;
  // Beats outside RD_DATA are not ours to check and are dropped here.
  assign rd_fire    = (state == RD_DATA) & rvalid;

  assign word_idx   = 24'(burst) * 24'(BURST_LEN) + 24'(beat);
  assign burst_addr = ADDR_WIDTH'(burst) * ADDR_WIDTH'(BURST_BYTES);

  // Same pattern generator serves both the write data and the read compare,
  // since pass_cnt only moves in DONE, after the read-back of the pass.
  always_comb begin
    pattern = '0;
    for (int j = 0; j < LANES; j++) begin
      pattern[j*32 +: 32] = {pass_cnt[7:0], word_idx} ^ {8'(j), 24'h0};
    end
  end

  assign rd_mismatch = rd_fire & (rdata != pattern);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= WAIT_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    arvalid    = 1'b0;
    case (state)
      WAIT_INIT: if (init_done) state_next = WR_ADDR;
      WR_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_next = WR_DATA;
      end
      WR_DATA: begin
        wvalid = 1'b1;
        if (wready && last_beat) state_next = last_burst ? RD_ADDR : WR_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: if (rvalid && rlast) state_next = last_burst ? DONE : RD_ADDR;
      DONE:    state_next = WR_ADDR;
      default: state_next = WAIT_INIT;
    endcase
    // Losing the controller overrides everything, including a pending handshake.
    if (!init_done) state_next = WAIT_INIT;
  end

  // Payload outputs are gated by their valid so idle/reset outputs read as 0.
  assign awaddr = awvalid ? burst_addr : '0;
  assign awlen  = awvalid ? LEN_FIELD  : '0;
  assign araddr = arvalid ? burst_addr : '0;
  assign arlen  = arvalid ? LEN_FIELD  : '0;
  assign wdata  = wvalid  ? pattern    : '0;
  assign wstrb  = wvalid  ? '1         : '0;
  assign wlast  = wvalid & last_beat;

  // --------------------------------------------------------------------------
  // Beat / burst position
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == WAIT_INIT) begin
      beat  <= '0;
      burst <= '0;
    end else if (wr_fire || rd_fire) begin
      // Writes close a burst on our own beat count, reads on the slave's rlast.
      if (wr_fire ? last_beat : rlast) begin
        beat  <= '0;
        burst <= last_burst ? '0 : burst + 1'b1;
      end else begin
        beat  <= beat + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Error and pass accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
      pass_err <= 1'b0;
      pass_cnt <= '0;
    end else begin
      if (rd_mismatch) begin
        err_flag <= 1'b1;
        pass_err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (state == DONE) begin
        if (!pass_err) pass_cnt <= pass_cnt + 16'd1;
        pass_err <= 1'b0;
      end else if (state == WAIT_INIT) begin
        pass_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Heartbeat
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == WAIT_INIT) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign led = {err_flag, blink};

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rw_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_rw_checker
// Purpose  : Self-checking bench for ddr3_rw_checker. A memory-backed slave
//            with selectable ready behaviour answers the user port, checks
//            addresses and write data against the pattern rule, and the test
//            tasks check counters, LEDs and control behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_rw_checker;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int BL = 16;
  localparam int NB = 64;
  localparam int BD = 50;
  localparam int NW = BL * NB;
  localparam int BYTES = DW / 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst, init_done;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic            awvalid, awready, wvalid, wlast, wready, arvalid, arready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic            rvalid, rlast;
  logic [1:0]      led;
  logic [15:0]     err_cnt, pass_cnt;

  always #5 sys_clk = ~sys_clk;

  ddr3_rw_checker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
    .TEST_BURSTS(NB), .BLINK_DIV(BD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .led(led), .err_cnt(err_cnt), .pass_cnt(pass_cnt)
  );

  localparam int OW = AW + 8 + 1 + DW + DW/8 + 1 + 1 + AW + 8 + 1 + 2 + 16 + 16;
  logic [OW-1:0] all_out;
  assign all_out = {awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast,
                    araddr, arlen, arvalid, led, err_cnt, pass_cnt};

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] model_pass = 16'd0;
  logic [DW-1:0] mem [NW];

  // Slave state and its observations
  int  mode = 0;             // 0 always ready, 1 wready toggles, 2 random
  int  aw_q[$], rq[$];
  int  aw_k, ar_k, wbeat, rbeat;
  int  wr_beats, rd_bursts;
  int  wdata_err = 0, wlast_err = 0, addr_err = 0, proto_err = 0;
  bit  aw_wait, ar_wait;
  logic [AW-1:0] aw_hold, ar_hold;
  bit  corrupt_armed = 0, corrupt_sent = 0;
  int  corrupt_w;
  int  blink_age, blink_toggles = 0, blink_err = 0;
  bit  blink_last_ok;
  logic blink_prev;

  // Expected data word, built straight from the pattern rule.
  function automatic logic [DW-1:0] pat(input logic [7:0] p, input int w);
    logic [DW-1:0] v;
    logic [31:0]   base;
    base = {p, 24'(w)};
    for (int j = 0; j < DW/32; j++) v[j*32 +: 32] = base ^ (32'(j) << 24);
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Memory slave: drives inputs at negedge, accounts handshakes just after.
  // --------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] d;
    int w;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst || !init_done) begin
        aw_q.delete(); rq.delete();
        aw_k = 0; ar_k = 0; wbeat = 0; rbeat = 0; wr_beats = 0; rd_bursts = 0;
        aw_wait = 0; ar_wait = 0; blink_last_ok = 0; blink_age = 0;
        blink_prev = led[0];
        rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
      end else begin
        case (mode)
          1: begin awready = 1'b1; arready = 1'b1; wready = ~wready; end
          2: begin
            awready = 1'($urandom_range(1));
            arready = 1'($urandom_range(1));
            wready  = 1'($urandom_range(1));
          end
          default: begin awready = 1'b1; arready = 1'b1; wready = 1'b1; end
        endcase
        if (rq.size() > 0 && !(mode == 2 && $urandom_range(3) == 0)) begin
          w = rq[0] + rbeat;
          d = mem[w];
          if (corrupt_armed && w == corrupt_w) begin
            d[0] = ~d[0];
            corrupt_armed = 0;
            corrupt_sent  = 1;
          end
          rvalid = 1'b1; rdata = d; rlast = (rbeat == BL - 1);
          rbeat++;
          if (rbeat == BL) begin
            rbeat = 0;
            void'(rq.pop_front());
            rd_bursts++;
          end
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        end
        #1;
        if (aw_wait && (!awvalid || awaddr !== aw_hold)) proto_err++;
        if (ar_wait && (!arvalid || araddr !== ar_hold)) proto_err++;
        aw_wait = awvalid && !awready; aw_hold = awaddr;
        ar_wait = arvalid && !arready; ar_hold = araddr;
        if (awvalid && awready) begin
          if (awaddr !== AW'(aw_k * BL * BYTES) || awlen !== 8'(BL - 1)) addr_err++;
          aw_q.push_back(int'(awaddr) / BYTES);
          aw_k = (aw_k + 1) % NB;
        end
        if (arvalid && arready) begin
          if (araddr !== AW'(ar_k * BL * BYTES) || arlen !== 8'(BL - 1)) addr_err++;
          rq.push_back(int'(araddr) / BYTES);
          ar_k = (ar_k + 1) % NB;
        end
        if (wvalid && wready) begin
          if (aw_q.size() == 0) begin
            proto_err++;
          end else begin
            w = aw_q[0] + wbeat;
            if (wdata !== pat(model_pass[7:0], w) || wstrb !== '1) wdata_err++;
            if (wlast !== (wbeat == BL - 1)) wlast_err++;
            if (w < NW) mem[w] = wdata;
            wr_beats++;
            wbeat++;
            if (wbeat == BL) begin
              wbeat = 0;
              void'(aw_q.pop_front());
            end
          end
        end
        blink_age++;
        if (led[0] !== blink_prev) begin
          blink_toggles++;
          if (blink_last_ok && blink_age != BD) blink_err++;
          blink_last_ok = 1;
          blink_age = 0;
        end
        blink_prev = led[0];
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #3;
  endtask

  // Waits for the read-back of a full pass; a clean pass advances the model.
  task automatic wait_pass(input bit clean);
    int n = 0;
    while (rd_bursts < NB && n < 20000) begin step(); n++; end
    checks++;
    if (rd_bursts < NB) begin
      errors++;
      $display("FAIL pass_timeout rd_bursts=%0d required=%0d", rd_bursts, NB);
    end
    checks++;
    if (wr_beats != NW) begin
      errors++;
      $display("FAIL write_beats got=%0d required=%0d", wr_beats, NW);
    end
    rd_bursts = 0;
    wr_beats  = 0;
    if (clean) model_pass = model_pass + 16'd1;
  endtask

  task automatic check_status(input string name, input logic [15:0] e_err, input logic e_led1);
    checks++;
    if (pass_cnt !== model_pass || err_cnt !== e_err || led[1] !== e_led1) begin
      errors++;
      $display("FAIL %s pass_cnt=%0d err_cnt=%0d led1=%b required %0d %0d %b",
               name, pass_cnt, err_cnt, led[1], model_pass, e_err, e_led1);
    end
    checks++;
    if (wdata_err != 0 || wlast_err != 0 || addr_err != 0 || proto_err != 0) begin
      errors++;
      $display("FAIL %s_slave wdata=%0d wlast=%0d addr=%0d proto=%0d required all 0",
               name, wdata_err, wlast_err, addr_err, proto_err);
    end
  endtask

  task automatic test_reset();
    bit seen = 0;
    sys_rst = 1'b1; init_done = 1'b0; mode = 0;
    repeat (3) step();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required 0", all_out);
    end
    sys_rst = 1'b0;
    repeat (120) begin
      step();
      if (all_out !== '0) seen = 1;
    end
    checks++;
    if (seen || led !== 2'b00) begin
      errors++;
      $display("FAIL idle_wait_init nonzero_seen=%0d led=%b required 0 00", seen, led);
    end
  endtask

  task automatic test_first_pass();
    int n = 0;
    init_done = 1'b1;
    checks++;
    if (awvalid !== 1'b0) begin
      errors++;
      $display("FAIL aw_latency_early awvalid=%b required 0", awvalid);
    end
    step();
    checks++;
    if ({awvalid, awaddr, awlen} !== {1'b1, AW'(0), 8'd15}) begin
      errors++;
      $display("FAIL first_aw valid=%b addr=%h len=%0d required 1 0 15", awvalid, awaddr, awlen);
    end
    while (!(awvalid && wr_beats >= BL) && n < 200) begin step(); n++; end
    checks++;
    if (awvalid !== 1'b1 || awaddr !== AW'(28'h100)) begin
      errors++;
      $display("FAIL second_aw valid=%b addr=%h required 1 100", awvalid, awaddr);
    end
    wait_pass(1);
    repeat (4) step();
    check_status("first_pass", 16'd0, 1'b0);
    checks++;
    if (blink_toggles < 2 || blink_err != 0) begin
      errors++;
      $display("FAIL heartbeat toggles=%0d bad_intervals=%0d required >=2 0", blink_toggles, blink_err);
    end
  endtask

  task automatic test_wready_toggle();
    mode = 1;
    wait_pass(1);
    repeat (4) step();
    check_status("wready_toggle", 16'd0, 1'b0);
  endtask

  task automatic test_random_stall();
    mode = 2;
    wait_pass(1);
    repeat (4) step();
    mode = 0;
    check_status("random_stall", 16'd0, 1'b0);
  endtask

  task automatic test_init_drop();
    int n = 0;
    while (!(wvalid && wr_beats >= 5) && n < 5000) begin step(); n++; end
    init_done = 1'b0;
    step();
    checks++;
    if ({awvalid, wvalid, arvalid} !== 3'b000) begin
      errors++;
      $display("FAIL init_drop_valids got=%b required 000", {awvalid, wvalid, arvalid});
    end
    step();
    checks++;
    if (led[0] !== 1'b0) begin
      errors++;
      $display("FAIL init_drop_led0 got=%b required 0", led[0]);
    end
    repeat (3) step();
    init_done = 1'b1;
    step();
    checks++;
    if (awvalid !== 1'b1 || awaddr !== AW'(0)) begin
      errors++;
      $display("FAIL restart_aw valid=%b addr=%h required 1 0", awvalid, awaddr);
    end
    wait_pass(1);
    repeat (4) step();
    check_status("init_restart", 16'd0, 1'b0);
  endtask

  task automatic test_corrupt();
    int n = 0;
    sys_rst = 1'b1;
    repeat (2) step();
    model_pass = 16'd0;
    corrupt_w = int'($urandom_range(NW - 1));
    corrupt_sent = 0;
    corrupt_armed = 1;
    sys_rst = 1'b0;
    while (!corrupt_sent && n < 10000) begin step(); n++; end
    checks++;
    if (!corrupt_sent || err_cnt !== 16'd0 || led[1] !== 1'b0) begin
      errors++;
      $display("FAIL pre_corrupt sent=%0d err_cnt=%0d led1=%b required 1 0 0", corrupt_sent, err_cnt, led[1]);
    end
    step();
    checks++;
    if (err_cnt !== 16'd1 || led[1] !== 1'b1) begin
      errors++;
      $display("FAIL post_corrupt err_cnt=%0d led1=%b required 1 1", err_cnt, led[1]);
    end
    wait_pass(0);
    repeat (4) step();
    check_status("corrupt_pass", 16'd1, 1'b1);
    wait_pass(1);
    repeat (4) step();
    check_status("after_corrupt", 16'd1, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    while (rd_bursts < 5 && n < 10000) begin step(); n++; end
    checks++;
    if (rd_bursts < 5) begin
      errors++;
      $display("FAIL reach_read rd_bursts=%0d required >=5", rd_bursts);
    end
    sys_rst = 1'b1;
    step();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_read_reset got=%h required 0", all_out);
    end
    model_pass = 16'd0;
    sys_rst = 1'b0;
    wait_pass(1);
    repeat (4) step();
    check_status("after_reset", 16'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_wready_toggle();
    test_random_stall();
    test_init_drop();
    test_corrupt();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
